// File: rtl/vga_if.sv
// vga_if: one VGA pixel-stream stage boundary.
//   vcount/hcount : current pixel coordinates
//   vsync/hsync   : sync pulses
//   vblnk/hblnk   : blanking flags
//   rgb           : 12-bit colour {r[3:0], g[3:0], b[3:0]}
// Modport "in" is the consumer view (upstream stream entering a stage).
// Modport "out" is the producer view (stream leaving a stage).
interface vga_if;
    logic [10:0] vcount;
    logic        vsync;
    logic        vblnk;
    logic [10:0] hcount;
    logic        hsync;
    logic        hblnk;
    logic [11:0] rgb;

    modport in (
        input vcount, vsync, vblnk, hcount, hsync, hblnk, rgb
    );

    modport out (
        output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb
    );
endinterface

// File: rtl/draw_projectile.sv
// draw_projectile: overlays a SPRITE_SIZE x SPRITE_SIZE thrown object on the
// VGA stream. The object follows a ballistic path that is updated once per
// frame, lands on the ground line (raising a hit pulse), stays visible for
// IMPACT_FRAMES frames and then disappears.
//
// Ports:
//   clk60MHz   pixel clock
//   rst        synchronous active-high reset
//   throw      single-cycle launch request (honoured only while idle)
//   start_x/y  launch top-left corner
//   start_vx/vy signed launch velocity, pixels per frame (vy < 0 is upward)
//   rgb_pixel  sprite ROM data, one cycle after pixel_addr
//   pixel_addr sprite ROM address {row, col}
//   busy       object in flight or showing its impact
//   hit        one-cycle pulse when the object lands
//   in / out   VGA stream, out = in delayed by two cycles plus overlay
module draw_projectile #(
    parameter int          SPRITE_SIZE   = 32,
    parameter int          H_LIMIT       = 1024,
    parameter int          GROUND_Y      = 700,
    parameter int          GRAVITY       = 1,
    parameter int          IMPACT_FRAMES = 30,
    parameter logic [11:0] KEY_COLOR     = 12'hF0F,
    localparam int         SB            = $clog2(SPRITE_SIZE)
) (
    input  logic          clk60MHz,
    input  logic          rst,
    input  logic          throw,
    input  logic [10:0]   start_x,
    input  logic [10:0]   start_y,
    input  logic [7:0]    start_vx,
    input  logic [7:0]    start_vy,
    input  logic [11:0]   rgb_pixel,
    output logic [2*SB-1:0] pixel_addr,
    output logic          busy,
    output logic          hit,
    vga_if.in             in,
    vga_if.out            out
);

    localparam int CNT_W = $clog2(IMPACT_FRAMES + 1);
    localparam logic signed [11:0] X_MAX    = 12'(H_LIMIT - SPRITE_SIZE);
    localparam logic signed [11:0] GROUND_S = 12'(GROUND_Y);
    localparam logic signed [11:0] GRAV_S   = 12'(GRAVITY);

    typedef enum logic [1:0] {IDLE, FLIGHT, IMPACT} state_t;

    state_t             state_reg, state_next;
    logic [10:0]        pos_x_reg, pos_x_next;
    logic [10:0]        pos_y_reg, pos_y_next;
    logic [7:0]         vx_reg, vx_next;
    logic [7:0]         vy_reg, vy_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic               hit_reg, hit_next;

    // Stage-1 copy of the incoming stream.
    logic [10:0] vcount_s1, hcount_s1;
    logic        vsync_s1, vblnk_s1, hsync_s1, hblnk_s1;
    logic [11:0] rgb_s1;
    logic        active_s1;
    logic        vblnk_prev_reg;

    logic               tick;
    logic signed [11:0] nx, ny, vy_sum;
    logic [7:0]         vy_sat;

    // Frame tick: rising edge of the registered vblank, so the position
    // only moves during vertical blanking.
    assign tick = vblnk_s1 & ~vblnk_prev_reg;

    assign nx     = $signed({1'b0, pos_x_reg}) + $signed({{4{vx_reg[7]}}, vx_reg});
    assign ny     = $signed({1'b0, pos_y_reg}) + $signed({{4{vy_reg[7]}}, vy_reg});
    assign vy_sum = $signed({{4{vy_reg[7]}}, vy_reg}) + GRAV_S;

    always_comb begin
        vy_sat = vy_sum[7:0];
        if (vy_sum > 12'sd127) begin
            vy_sat = 8'h7F;
        end else if (vy_sum < -12'sd128) begin
            vy_sat = 8'h80;
        end
    end

    always_comb begin
        state_next = state_reg;
        pos_x_next = pos_x_reg;
        pos_y_next = pos_y_reg;
        vx_next    = vx_reg;
        vy_next    = vy_reg;
        cnt_next   = cnt_reg;
        hit_next   = 1'b0;
        case (state_reg)
            IDLE: begin
                // A launch beats a coinciding tick: the first move waits
                // for the next frame.
                if (throw) begin
                    pos_x_next = start_x;
                    pos_y_next = start_y;
                    vx_next    = start_vx;
                    vy_next    = start_vy;
                    state_next = FLIGHT;
                end
            end
            FLIGHT: begin
                if (tick) begin
                    vy_next = vy_sat;
                    if (nx < 12'sd0 || nx > X_MAX) begin
                        // Left the screen sideways: vanish without a hit.
                        state_next = IDLE;
                    end else if (ny >= GROUND_S) begin
                        pos_x_next = nx[10:0];
                        pos_y_next = GROUND_S[10:0];
                        hit_next   = 1'b1;
                        cnt_next   = CNT_W'(IMPACT_FRAMES - 1);
                        state_next = IMPACT;
                    end else if (ny < 12'sd0) begin
                        // Ceiling clamp; velocity is not reflected.
                        pos_x_next = nx[10:0];
                        pos_y_next = 11'd0;
                    end else begin
                        pos_x_next = nx[10:0];
                        pos_y_next = ny[10:0];
                    end
                end
            end
            IMPACT: begin
                if (tick) begin
                    if (cnt_reg == '0) begin
                        state_next = IDLE;
                    end else begin
                        cnt_next = cnt_reg - 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk60MHz) begin
        if (rst) begin
            state_reg <= IDLE;
            pos_x_reg <= '0;
            pos_y_reg <= '0;
            vx_reg    <= '0;
            vy_reg    <= '0;
            cnt_reg   <= '0;
            hit_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            pos_x_reg <= pos_x_next;
            pos_y_reg <= pos_y_next;
            vx_reg    <= vx_next;
            vy_reg    <= vy_next;
            cnt_reg   <= cnt_next;
            hit_reg   <= hit_next;
        end
    end

    assign busy = (state_reg != IDLE);
    assign hit  = hit_reg;

    // Only the low SB bits of the offsets matter for the ROM address, and
    // the low bits of a difference depend only on the low bits of operands.
    assign pixel_addr = {in.vcount[SB-1:0] - pos_y_reg[SB-1:0],
                         in.hcount[SB-1:0] - pos_x_reg[SB-1:0]};

    // Sprite bounding box test on the stage-1 coordinates.
    logic [11:0] h_ext, v_ext, x_lo, y_lo;
    logic        in_box, draw_sprite;

    assign h_ext  = {1'b0, hcount_s1};
    assign v_ext  = {1'b0, vcount_s1};
    assign x_lo   = {1'b0, pos_x_reg};
    assign y_lo   = {1'b0, pos_y_reg};
    assign in_box = (h_ext >= x_lo) && (h_ext < x_lo + 12'(SPRITE_SIZE)) &&
                    (v_ext >= y_lo) && (v_ext < y_lo + 12'(SPRITE_SIZE));
    assign draw_sprite = active_s1 && !vblnk_s1 && !hblnk_s1 && in_box &&
                         (rgb_pixel != KEY_COLOR);

    always_ff @(posedge clk60MHz) begin
        if (rst) begin
            vcount_s1      <= '0;
            vsync_s1       <= 1'b0;
            vblnk_s1       <= 1'b0;
            hcount_s1      <= '0;
            hsync_s1       <= 1'b0;
            hblnk_s1       <= 1'b0;
            rgb_s1         <= '0;
            active_s1      <= 1'b0;
            vblnk_prev_reg <= 1'b0;
            out.vcount     <= '0;
            out.vsync      <= 1'b0;
            out.vblnk      <= 1'b0;
            out.hcount     <= '0;
            out.hsync      <= 1'b0;
            out.hblnk      <= 1'b0;
            out.rgb        <= '0;
        end else begin
            vcount_s1      <= in.vcount;
            vsync_s1       <= in.vsync;
            vblnk_s1       <= in.vblnk;
            hcount_s1      <= in.hcount;
            hsync_s1       <= in.hsync;
            hblnk_s1       <= in.hblnk;
            rgb_s1         <= in.rgb;
            // Draw enable is captured alongside the pixel it applies to.
            active_s1      <= (state_reg != IDLE);
            vblnk_prev_reg <= vblnk_s1;
            out.vcount     <= vcount_s1;
            out.vsync      <= vsync_s1;
            out.vblnk      <= vblnk_s1;
            out.hcount     <= hcount_s1;
            out.hsync      <= hsync_s1;
            out.hblnk      <= hblnk_s1;
            out.rgb        <= draw_sprite ? rgb_pixel : rgb_s1;
        end
    end

endmodule

// File: tb/tb_draw_projectile.sv
module tb_draw_projectile;

    localparam logic [11:0] KEY = 12'hF0F;

    logic        clk60MHz = 1'b0;
    logic        rst = 1'b1;
    logic        throw = 1'b0;
    logic [10:0] start_x = '0, start_y = '0;
    logic [7:0]  start_vx = '0, start_vy = '0;
    logic [11:0] rgb_pixel;
    logic [9:0]  pixel_addr;
    logic        busy, hit;

    vga_if vga_in ();
    vga_if vga_out ();

    draw_projectile dut (
        .clk60MHz  (clk60MHz),
        .rst       (rst),
        .throw     (throw),
        .start_x   (start_x),
        .start_y   (start_y),
        .start_vx  (start_vx),
        .start_vy  (start_vy),
        .rgb_pixel (rgb_pixel),
        .pixel_addr(pixel_addr),
        .busy      (busy),
        .hit       (hit),
        .in        (vga_in),
        .out       (vga_out)
    );

    always #8 clk60MHz = ~clk60MHz;

    // Sprite ROM with one-cycle read latency.
    logic [11:0] rom [0:1023];
    always @(posedge clk60MHz) rgb_pixel <= rom[pixel_addr];

    // Hit pulse monitor.
    int   hit_pulses = 0;
    int   hit_cycles = 0;
    logic hit_q = 1'b0;
    always @(negedge clk60MHz) begin
        hit_q <= hit;
        if (hit === 1'b1 && hit_q !== 1'b1) hit_pulses <= hit_pulses + 1;
        if (hit === 1'b1) hit_cycles <= hit_cycles + 1;
    end

    int tests = 0;
    int fails = 0;

    // Behavioural model: plain integer kinematics per frame.
    int m_state = 0;   // 0 idle, 1 flying, 2 landed
    int m_x, m_y, m_vx, m_vy;
    int m_frames_left;
    int m_hits = 0;

    task automatic model_throw(input int x, input int y, input int vx, input int vy);
        if (m_state == 0) begin
            m_x = x; m_y = y; m_vx = vx; m_vy = vy;
            m_state = 1;
        end
    endtask

    task automatic model_tick();
        int nx, ny;
        if (m_state == 1) begin
            nx = m_x + m_vx;
            ny = m_y + m_vy;
            m_vy = m_vy + 1;
            if (m_vy > 127) m_vy = 127;
            if (m_vy < -128) m_vy = -128;
            if (nx < 0 || nx > 1024 - 32) begin
                m_state = 0;
            end else if (ny >= 700) begin
                m_x = nx; m_y = 700;
                m_hits++;
                m_frames_left = 30;
                m_state = 2;
            end else if (ny < 0) begin
                m_x = nx; m_y = 0;
            end else begin
                m_x = nx; m_y = ny;
            end
        end else if (m_state == 2) begin
            m_frames_left--;
            if (m_frames_left == 0) m_state = 0;
        end
    endtask

    function automatic logic [11:0] exp_pixel(input int h, input int v,
                                              input logic [11:0] bg, input logic hb);
        int addr;
        if (m_state != 0 && !hb && h >= m_x && h < m_x + 32 && v >= m_y && v < m_y + 32) begin
            addr = (v - m_y) * 32 + (h - m_x);
            if (rom[addr] != KEY) return rom[addr];
        end
        return bg;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic get_pixel(input int h, input int v, input logic [11:0] bg,
                             input logic hb, output logic [11:0] got);
        vga_in.hcount = 11'(h);
        vga_in.vcount = 11'(v);
        vga_in.rgb    = bg;
        vga_in.hblnk  = hb;
        vga_in.vblnk  = 1'b0;
        @(posedge clk60MHz);
        @(posedge clk60MHz);
        #1;
        got = vga_out.rgb;
        vga_in.hblnk = 1'b0;
    endtask

    task automatic do_throw(input int x, input int y, input int vx, input int vy);
        start_x  = 11'(x);
        start_y  = 11'(y);
        start_vx = 8'(vx);
        start_vy = 8'(vy);
        throw = 1'b1;
        @(posedge clk60MHz);
        #1;
        throw = 1'b0;
        model_throw(x, y, vx, vy);
    endtask

    task automatic do_tick();
        vga_in.vblnk = 1'b1;
        repeat (3) @(posedge clk60MHz);
        #1;
        vga_in.vblnk = 1'b0;
        repeat (3) @(posedge clk60MHz);
        #1;
        model_tick();
    endtask

    task automatic tick_with_throw(input int x, input int y, input int vx, input int vy);
        vga_in.vblnk = 1'b1;
        @(posedge clk60MHz);
        #1;
        start_x  = 11'(x);
        start_y  = 11'(y);
        start_vx = 8'(vx);
        start_vy = 8'(vy);
        throw = 1'b1;
        @(posedge clk60MHz);
        #1;
        throw = 1'b0;
        @(posedge clk60MHz);
        #1;
        vga_in.vblnk = 1'b0;
        repeat (3) @(posedge clk60MHz);
        #1;
        if (m_state == 0) model_throw(x, y, vx, vy);
        else model_tick();
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk60MHz);
        #1;
        rst = 1'b0;
        m_state = 0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [11:0] got;
        int hp0;
        rst = 1'b1;
        throw = 1'b1;
        start_x = 11'd50; start_y = 11'd60; start_vx = 8'd3; start_vy = 8'd2;
        vga_in.hcount = 11'd300; vga_in.vcount = 11'd200; vga_in.rgb = 12'h456;
        vga_in.hsync = 1'b1; vga_in.vsync = 1'b1; vga_in.hblnk = 1'b0; vga_in.vblnk = 1'b0;
        repeat (3) @(posedge clk60MHz);
        #1;
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
        tests++;
        if (hit !== 1'b0) begin fails++; $display("FAIL reset_hit: got %b expected 0", hit); end
        tests++;
        if ({vga_out.hcount, vga_out.vcount, vga_out.hsync, vga_out.vsync,
             vga_out.hblnk, vga_out.vblnk, vga_out.rgb} !== 39'd0) begin
            fails++;
            $display("FAIL reset_out: got h=%0d v=%0d rgb=%h expected all zero",
                     vga_out.hcount, vga_out.vcount, vga_out.rgb);
        end
        rst = 1'b0;
        throw = 1'b0;
        vga_in.hsync = 1'b0; vga_in.vsync = 1'b0;
        m_state = 0;
        get_pixel(10, 20, 12'h123, 1'b0, got);
        tests++;
        if (got !== 12'h123 || vga_out.hcount !== 11'd10 || vga_out.vcount !== 11'd20) begin
            fails++;
            $display("FAIL reset_release_passthru: got rgb=%h h=%0d v=%0d expected 123 10 20",
                     got, vga_out.hcount, vga_out.vcount);
        end
        // Reset during flight aborts without a hit.
        do_throw(200, 690, 0, 20);
        hp0 = hit_pulses;
        pulse_reset();
        do_tick();
        tests++;
        if (busy !== 1'b0 || hit_pulses !== hp0) begin
            fails++;
            $display("FAIL reset_midflight: got busy=%b hits=%0d expected 0 %0d", busy, hit_pulses, hp0);
        end
    endtask

    task automatic test_passthrough();
        logic [11:0] got;
        get_pixel(7, 3, 12'h111, 1'b0, got);
        vga_in.hcount = 11'd100; vga_in.vcount = 11'd50; vga_in.rgb = 12'hABC; vga_in.hsync = 1'b1;
        @(posedge clk60MHz);
        #1;
        tests++;
        if (vga_out.hcount !== 11'd7) begin
            fails++;
            $display("FAIL passthru_latency1: got hcount=%0d expected 7", vga_out.hcount);
        end
        @(posedge clk60MHz);
        #1;
        tests++;
        if (vga_out.hcount !== 11'd100 || vga_out.vcount !== 11'd50 ||
            vga_out.rgb !== 12'hABC || vga_out.hsync !== 1'b1) begin
            fails++;
            $display("FAIL passthru_latency2: got h=%0d v=%0d rgb=%h hs=%b expected 100 50 abc 1",
                     vga_out.hcount, vga_out.vcount, vga_out.rgb, vga_out.hsync);
        end
        vga_in.hsync = 1'b0;
    endtask

    task automatic test_launch();
        logic [11:0] got, exp;
        do_throw(100, 600, 4, -10);
        tests++;
        if (busy !== 1'b1) begin fails++; $display("FAIL launch_busy: got %b expected 1", busy); end
        do_tick();
        get_pixel(104, 590, 12'h3C3, 1'b0, got);
        exp = exp_pixel(104, 590, 12'h3C3, 1'b0);
        tests++;
        if (got !== exp || got !== rom[0]) begin
            fails++; $display("FAIL launch_word0: got %h expected %h", got, exp);
        end
        get_pixel(109, 590, 12'h3C3, 1'b0, got);
        tests++;
        if (got !== 12'h3C3) begin fails++; $display("FAIL launch_keycolor: got %h expected 3c3", got); end
        get_pixel(103, 590, 12'h3C3, 1'b0, got);
        tests++;
        if (got !== 12'h3C3) begin fails++; $display("FAIL launch_left_edge: got %h expected 3c3", got); end
        get_pixel(135, 621, 12'h3C3, 1'b0, got);
        exp = exp_pixel(135, 621, 12'h3C3, 1'b0);
        tests++;
        if (got !== exp) begin fails++; $display("FAIL launch_corner: got %h expected %h", got, exp); end
        get_pixel(136, 621, 12'h3C3, 1'b0, got);
        tests++;
        if (got !== 12'h3C3) begin fails++; $display("FAIL launch_right_edge: got %h expected 3c3", got); end
        get_pixel(104, 590, 12'h3C3, 1'b1, got);
        tests++;
        if (got !== 12'h3C3) begin fails++; $display("FAIL launch_hblank: got %h expected 3c3", got); end
        // Second frame: vy has become -9.
        do_tick();
        get_pixel(108, 581, 12'h0F0, 1'b0, got);
        tests++;
        if (got !== rom[0]) begin fails++; $display("FAIL launch_second_move: got %h expected %h", got, rom[0]); end
        pulse_reset();
    endtask

    task automatic test_landing();
        logic [11:0] got;
        int hp0, hc0;
        hp0 = hit_pulses; hc0 = hit_cycles;
        do_throw(200, 690, 0, 5);
        do_tick();
        tests++;
        if (hit_pulses !== hp0) begin fails++; $display("FAIL land_early_hit: got %0d expected %0d", hit_pulses, hp0); end
        do_tick();
        tests++;
        if (hit_pulses !== hp0 + 1 || hit_cycles !== hc0 + 1) begin
            fails++;
            $display("FAIL land_hit_pulse: got pulses=%0d cycles=%0d expected %0d %0d",
                     hit_pulses, hit_cycles, hp0 + 1, hc0 + 1);
        end
        get_pixel(200, 700, 12'h222, 1'b0, got);
        tests++;
        if (got !== rom[0]) begin fails++; $display("FAIL land_ground_y: got %h expected %h", got, rom[0]); end
        repeat (29) do_tick();
        tests++;
        if (busy !== 1'b1) begin fails++; $display("FAIL land_impact_hold: got busy=%b expected 1", busy); end
        get_pixel(200, 700, 12'h222, 1'b0, got);
        tests++;
        if (got !== rom[0]) begin fails++; $display("FAIL land_frozen: got %h expected %h", got, rom[0]); end
        do_tick();
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL land_impact_end: got busy=%b expected 0", busy); end
    endtask

    task automatic test_offscreen();
        logic [11:0] got;
        int hp0;
        hp0 = hit_pulses;
        do_throw(990, 100, 5, 0);
        get_pixel(990, 100, 12'h555, 1'b0, got);
        tests++;
        if (got !== rom[0]) begin fails++; $display("FAIL offscreen_drawn_before: got %h expected %h", got, rom[0]); end
        do_tick();
        tests++;
        if (busy !== 1'b0 || hit_pulses !== hp0) begin
            fails++; $display("FAIL offscreen_idle: got busy=%b hits=%0d expected 0 %0d", busy, hit_pulses, hp0);
        end
        get_pixel(995, 100, 12'h555, 1'b0, got);
        tests++;
        if (got !== 12'h555) begin fails++; $display("FAIL offscreen_no_draw: got %h expected 555", got); end
    endtask

    task automatic test_simultaneous();
        logic [11:0] got, exp;
        tick_with_throw(300, 400, 3, -2);
        get_pixel(300, 400, 12'h777, 1'b0, got);
        exp = exp_pixel(300, 400, 12'h777, 1'b0);
        tests++;
        if (got !== exp || got !== rom[0]) begin
            fails++; $display("FAIL simul_load_wins: got %h expected %h", got, exp);
        end
        // Throw while flying is ignored.
        do_throw(50, 50, -3, 7);
        do_tick();
        get_pixel(303, 398, 12'h777, 1'b0, got);
        exp = exp_pixel(303, 398, 12'h777, 1'b0);
        tests++;
        if (got !== exp || got !== rom[0]) begin
            fails++; $display("FAIL ignored_throw: got %h expected %h", got, exp);
        end
        get_pixel(50, 50, 12'h777, 1'b0, got);
        tests++;
        if (got !== 12'h777) begin fails++; $display("FAIL ignored_throw_pos: got %h expected 777", got); end
        pulse_reset();
    endtask

    task automatic test_random();
        logic [11:0] got, exp, bg;
        int x, y, vx, vy, h, v;
        for (int n = 0; n < 6; n++) begin
            x  = int'($urandom_range(0, 992));
            y  = int'($urandom_range(300, 650));
            vx = int'($urandom_range(0, 16)) - 8;
            vy = int'($urandom_range(0, 30)) - 20;
            do_throw(x, y, vx, vy);
            for (int t = 0; t < 120 && m_state != 0; t++) begin
                do_tick();
                tests++;
                if (busy !== (m_state != 0) || hit_pulses !== m_hits) begin
                    fails++;
                    $display("FAIL rand_state n=%0d t=%0d: got busy=%b hits=%0d expected %b %0d",
                             n, t, busy, hit_pulses, (m_state != 0), m_hits);
                end
                for (int p = 0; p < 2; p++) begin
                    h = m_x + int'($urandom_range(0, 35)) - 2;
                    v = m_y + int'($urandom_range(0, 35)) - 2;
                    if (h < 0) h = 0;
                    if (v < 0) v = 0;
                    bg = 12'($urandom);
                    get_pixel(h, v, bg, 1'b0, got);
                    exp = exp_pixel(h, v, bg, 1'b0);
                    tests++;
                    if (got !== exp) begin
                        fails++;
                        $display("FAIL rand_pixel n=%0d t=%0d (%0d,%0d): got %h expected %h",
                                 n, t, h, v, got, exp);
                    end
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            rom[i] = 12'($urandom);
            if (rom[i] == KEY) rom[i] = 12'h000;
            if (i % 7 == 3) rom[i] = KEY;
        end
        rom[0] = 12'hA5A;
        rom[5] = KEY;
        vga_in.hcount = '0; vga_in.vcount = '0; vga_in.rgb = '0;
        vga_in.hsync = 1'b0; vga_in.vsync = 1'b0; vga_in.hblnk = 1'b0; vga_in.vblnk = 1'b0;
        #1;
        test_reset();
        test_passthrough();
        test_launch();
        test_landing();
        test_offscreen();
        test_simultaneous();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/draw_projectile.md
Name: draw_projectile

Overview:
- Downstream overlay stage in the VGA pixel chain. It draws a 32x32 thrown object, such as a bone or ball, on top of the incoming stream.
- The object moves on a ballistic trajectory, updated once per frame. It lands on the ground line and raises a hit pulse for game logic.
- Sprite pixels come from an external synchronous ROM with 1-cycle read latency, addressed by this block.
- Timing signals pass through with 2-cycle latency, matching the other draw stages.

Parameters:
- SPRITE_SIZE, 32: sprite width and height in pixels (power of two).
- H_LIMIT, 1024: visible width; the object must satisfy 0 <= x <= H_LIMIT-SPRITE_SIZE.
- GROUND_Y, 700: top-row y coordinate at which the object lands.
- GRAVITY, 1: added to vy every frame (signed).
- IMPACT_FRAMES, 30: number of frames the landed sprite stays visible.
- KEY_COLOR, 12'hF0F: transparent colour in the sprite ROM.

Ports:
- clk60MHz, input, 1: pixel clock.
- rst, input, 1: synchronous, active-high reset.
- throw, input, 1: single-cycle launch request.
- start_x, input, 11: launch x (top-left corner).
- start_y, input, 11: launch y (top-left corner).
- start_vx, input, 8: signed initial x velocity, in pixels per frame.
- start_vy, input, 8: signed initial y velocity; negative means upward.
- rgb_pixel, input, 12: ROM data, valid 1 cycle after pixel_addr.
- pixel_addr, output, 10: ROM address {row[4:0], col[4:0]}.
- busy, output, 1: high when state is not IDLE.
- hit, output, 1: 1-cycle pulse on landing.
- in, vga_if.in: upstream timing and rgb.
- out, vga_if.out: downstream timing and rgb.

Behaviour:
- Reset: state=IDLE. pos_x, pos_y, vx, vy, impact counter = 0. busy=0, hit=0. All out.* fields = 0. Reset mid-flight aborts immediately with no hit.
- Frame tick: 1-cycle strobe when a registered copy of in.vblnk shows a 0->1 edge. Position changes only on the tick, so it is stable across the visible area.
- IDLE:
  - throw=1 loads pos_x=start_x, pos_y=start_y, vx=sign-extended start_vx, vy=sign-extended start_vy, then goes to FLIGHT.
  - If throw and tick occur in the same cycle, the load wins. The first move happens on the next tick.
- FLIGHT, on each tick, with signed 12-bit arithmetic:
  - nx = pos_x + vx.
  - ny = pos_y + vy.
  - vy <= vy + GRAVITY, saturating at +127 and -128.
  - If nx < 0 or nx > H_LIMIT-SPRITE_SIZE: go to IDLE, no hit, position unchanged.
  - Else if ny >= GROUND_Y: pos_y <= GROUND_Y, pos_x <= nx, hit=1 for one cycle, counter <= IMPACT_FRAMES-1, go to IMPACT.
  - Else if ny < 0: pos_y <= 0. Flight continues (ceiling clamp, vy unchanged).
  - Else: pos_x <= nx, pos_y <= ny.
  - The x-out-of-range check has priority over landing.
- IMPACT: the sprite is frozen and drawn. On each tick the counter decrements. At counter==0 on a tick, go to IDLE.
- throw is ignored in FLIGHT and IMPACT.
- Pixel pipeline, 2-cycle latency for all fields:
  - Stage 1 registers in.*.
  - pixel_addr = {(in.vcount-pos_y)[4:0], (in.hcount-pos_x)[4:0]}, computed combinationally from the unregistered counters.
  - Stage 2 outputs the stage-1 timing fields unchanged.
  - out.rgb = rgb_pixel only when all of the following hold on the stage-1 values:
    - state != IDLE;
    - not vblnk and not hblnk;
    - pos_x <= hcount < pos_x+SPRITE_SIZE;
    - pos_y <= vcount < pos_y+SPRITE_SIZE;
    - rgb_pixel != KEY_COLOR.
  - Otherwise out.rgb = stage-1 rgb.
- The state used for drawing is sampled in the same cycle as the stage-1 registers, so a transition mid-line causes no partial-row tearing beyond that cycle.

Test Plan:
- Reset: hold rst 3 cycles mid-frame with throw=1 -> busy=0, hit=0, out.rgb=0, all out.* = 0; after release, out matches in delayed by 2 cycles (upstream rgb=12'h123 appears unchanged).
- Pass-through latency: state IDLE, in.hcount=100, vcount=50, rgb=12'hABC -> exactly 2 cycles later out.hcount=100, out.vcount=50, out.rgb=12'hABC.
- Launch and draw: throw with x=100, y=600, vx=4, vy=-10 -> busy=1. After 1 tick pos=(104,590) and vy=-9. Pixel (104,590) shows ROM word 0. ROM returning 12'hF0F at address 5 -> background is passed at (109,590).
- Landing: x=200, y=690, vx=0, vy=5 -> after 2 ticks ny=701>=700, so pos_y=700, a single-cycle hit pulse, state IMPACT. After 30 more ticks busy=0.
- Off-screen: x=990, vx=5 -> after 1 tick nx=995 > 992 -> IDLE, hit never asserted, no sprite pixels drawn.
- Simultaneous and ignored events: throw coincident with tick -> pos equals start values after that cycle. A second throw during FLIGHT with different start values -> trajectory unaffected.
